// File: rtl/rtc_pps_alarm.sv
// rtc_pps_alarm: 1PPS pulse generator, rollover counter, seconds-jump
// detector and single armable alarm driven by the RTC time-of-day outputs.
module rtc_pps_alarm #(
  parameter int PPS_W_BITS = 16,
  parameter int CNT_BITS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [37:0]           time_reg_ns,
  input  logic [47:0]           time_reg_sec,
  input  logic                  time_ld,
  input  logic [PPS_W_BITS-1:0] pps_width,
  input  logic                  alarm_ld,
  input  logic                  alarm_cancel,
  input  logic [47:0]           alarm_sec_in,
  input  logic [29:0]           alarm_ns_in,
  output logic                  pps_out,
  output logic [CNT_BITS-1:0]   pps_count,
  output logic                  sec_jump,
  output logic                  alarm_armed,
  output logic                  alarm_pulse,
  output logic                  alarm_late
);

  localparam logic [PPS_W_BITS-1:0] PPS_ONE = PPS_W_BITS'(1);
  localparam logic [CNT_BITS-1:0]   CNT_ONE = CNT_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2
  } alarm_state_t;

  // Seconds history; ld_dly_q resets high so the first sample after reset
  // is treated as a resync rather than a rollover.
  logic [47:0]           sec_dly_q;
  logic                  ld_dly_q;
  logic [PPS_W_BITS-1:0] pps_cnt_q;
  logic                  pps_out_q;
  logic [CNT_BITS-1:0]   pps_count_q;
  logic                  sec_jump_q;

  alarm_state_t          state_q;
  logic [47:0]           tgt_sec_q;
  logic [29:0]           tgt_ns_q;
  logic                  first_q;
  logic                  late_q;
  logic                  pulse_q;
  logic                  armed_q;

  logic [47:0] sec_inc;
  logic        chg;
  logic        roll;
  logic        ge;

  // 48-bit increment wraps naturally, so all-ones -> 0 is a legal rollover.
  assign sec_inc = sec_dly_q + 48'd1;
  assign chg     = (time_reg_sec != sec_dly_q) && !ld_dly_q;
  assign roll    = chg && (time_reg_sec == sec_inc);
  // Integer ns only; the fraction byte is deliberately ignored.
  assign ge      = {time_reg_sec, time_reg_ns[37:8]} >= {tgt_sec_q, tgt_ns_q};

  // Delay the seconds value and the load strobe, and flag illegal jumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_dly_q  <= '0;
      ld_dly_q   <= 1'b1;
      sec_jump_q <= 1'b0;
    end else begin
      sec_dly_q  <= time_reg_sec;
      ld_dly_q   <= time_ld;
      sec_jump_q <= chg && !roll;
    end
  end

  // Pulse-width down-counter; a roll reloads it so back-to-back pulses merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_cnt_q <= '0;
      pps_out_q <= 1'b0;
    end else if (roll) begin
      pps_cnt_q <= pps_width;
      pps_out_q <= (pps_width != '0);
    end else if (pps_cnt_q != '0) begin
      pps_cnt_q <= pps_cnt_q - PPS_ONE;
      pps_out_q <= (pps_cnt_q != PPS_ONE);
    end
  end

  // Count every legitimate rollover, independent of the pulse width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_count_q <= '0;
    end else if (roll) begin
      pps_count_q <= pps_count_q + CNT_ONE;
    end
  end

  // Alarm FSM: cancel beats load, load beats the normal state progression.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tgt_sec_q <= '0;
      tgt_ns_q  <= '0;
      first_q   <= 1'b0;
      late_q    <= 1'b0;
      pulse_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (alarm_cancel) begin
        state_q <= S_IDLE;
        armed_q <= 1'b0;
      end else if (alarm_ld) begin
        tgt_sec_q <= alarm_sec_in;
        tgt_ns_q  <= alarm_ns_in;
        late_q    <= 1'b0;
        first_q   <= 1'b1;
        state_q   <= S_ARMED;
        armed_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            armed_q <= 1'b0;
          end
          S_ARMED: begin
            if (ge) begin
              state_q <= S_FIRE;
              pulse_q <= 1'b1;
              late_q  <= first_q;
              armed_q <= 1'b0;
            end else begin
              first_q <= 1'b0;
            end
          end
          S_FIRE: begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pps_out     = pps_out_q;
  assign pps_count   = pps_count_q;
  assign sec_jump    = sec_jump_q;
  assign alarm_armed = armed_q;
  assign alarm_pulse = pulse_q;
  assign alarm_late  = late_q;

endmodule

// File: tb/tb_rtc_pps_alarm.sv
// tb_rtc_pps_alarm: table-driven PPS/jump vectors plus directed alarm and
// reset sequences for rtc_pps_alarm.
module tb_rtc_pps_alarm;

  localparam logic [47:0] SEC_MAX = 48'hFFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec;
  logic        time_ld;
  logic [15:0] pps_width;
  logic        alarm_ld;
  logic        alarm_cancel;
  logic [47:0] alarm_sec_in;
  logic [29:0] alarm_ns_in;
  logic        pps_out;
  logic [31:0] pps_count;
  logic        sec_jump;
  logic        alarm_armed;
  logic        alarm_pulse;
  logic        alarm_late;

  int total;
  int bad;

  rtc_pps_alarm #(.PPS_W_BITS(16), .CNT_BITS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .time_reg_ns  (time_reg_ns),
    .time_reg_sec (time_reg_sec),
    .time_ld      (time_ld),
    .pps_width    (pps_width),
    .alarm_ld     (alarm_ld),
    .alarm_cancel (alarm_cancel),
    .alarm_sec_in (alarm_sec_in),
    .alarm_ns_in  (alarm_ns_in),
    .pps_out      (pps_out),
    .pps_count    (pps_count),
    .sec_jump     (sec_jump),
    .alarm_armed  (alarm_armed),
    .alarm_pulse  (alarm_pulse),
    .alarm_late   (alarm_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] sec;
    logic        ld;
    logic [15:0] w;
    logic        pps;
    logic        jump;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [47:0] sec, input logic ld, input logic [15:0] w,
                              input logic pps, input logic jump, input logic [31:0] cnt);
    vec_t v;
    v.sec = sec; v.ld = ld; v.w = w; v.pps = pps; v.jump = jump; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ns(input logic [29:0] ns);
    time_reg_ns = {ns, 8'hA5};
  endtask

  initial begin
    rst_n = 1'b0; time_reg_sec = 48'd5; time_ld = 1'b0; pps_width = 16'd4;
    alarm_ld = 1'b0; alarm_cancel = 1'b0; alarm_sec_in = '0; alarm_ns_in = '0;
    set_ns(30'd0);
    total = 0; bad = 0;

    // Roll 5->6 with width 4
    add(48'd5, 0, 16'd4, 0, 0, 0);
    add(48'd5, 0, 16'd4, 0, 0, 0);
    add(48'd6, 0, 16'd4, 1, 0, 1);
    for (int k = 0; k < 3; k++) add(48'd6, 0, 16'd4, 1, 0, 1);
    add(48'd6, 0, 16'd4, 0, 0, 1);
    add(48'd6, 0, 16'd4, 0, 0, 1);
    // Resync via time_ld, then an unannounced jump
    add(48'd6,   1, 16'd4, 0, 0, 1);
    add(48'd100, 0, 16'd4, 0, 0, 1);
    add(48'd100, 0, 16'd4, 0, 0, 1);
    add(48'd200, 0, 16'd4, 0, 1, 1);
    add(48'd200, 0, 16'd4, 0, 0, 1);
    // Resync to all-ones, wrap to 0 with width 0
    add(48'd200, 1, 16'd4, 0, 0, 1);
    add(SEC_MAX, 0, 16'd4, 0, 0, 1);
    add(SEC_MAX, 0, 16'd0, 0, 0, 1);
    add(48'd0,   0, 16'd0, 0, 0, 2);
    add(48'd0,   0, 16'd0, 0, 0, 2);
    // 10-cycle pulse restarted after 2 cycles; width change mid-pulse ignored
    add(48'd1, 0, 16'd10, 1, 0, 3);
    add(48'd1, 0, 16'd10, 1, 0, 3);
    add(48'd2, 0, 16'd10, 1, 0, 4);
    for (int k = 0; k < 9; k++) add(48'd2, 0, 16'd3, 1, 0, 4);
    add(48'd2, 0, 16'd3, 0, 0, 4);
    add(48'd2, 0, 16'd3, 0, 0, 4);

    // Reset state
    step();
    step();
    chk("rst_pps", 64'(pps_out), 64'd0);
    chk("rst_cnt", 64'(pps_count), 64'd0);
    chk("rst_jump", 64'(sec_jump), 64'd0);
    chk("rst_armed", 64'(alarm_armed), 64'd0);
    chk("rst_pulse", 64'(alarm_pulse), 64'd0);
    chk("rst_late", 64'(alarm_late), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      time_reg_sec = vecs[i].sec;
      time_ld      = vecs[i].ld;
      pps_width    = vecs[i].w;
      step();
      $display("vec %0d sec=%0h ld=%0b w=%0d -> pps=%0b jump=%0b cnt=%0d",
               i, vecs[i].sec, vecs[i].ld, vecs[i].w, pps_out, sec_jump, pps_count);
      chk($sformatf("vec%0d_pps", i), 64'(pps_out), 64'(vecs[i].pps));
      chk($sformatf("vec%0d_jump", i), 64'(sec_jump), 64'(vecs[i].jump));
      chk($sformatf("vec%0d_cnt", i), 64'(pps_count), 64'(vecs[i].cnt));
    end

    // Move RTC to 10 s via a time load
    time_ld = 1'b1; time_reg_sec = 48'd2; step();
    time_ld = 1'b0; time_reg_sec = 48'd10; step();

    // Alarm at 10 s / 500 ns, RTC from 400 ns in 8 ns steps: ge first at k=13
    alarm_sec_in = 48'd10; alarm_ns_in = 30'd500;
    for (int k = 0; k < 16; k++) begin
      set_ns(30'(400 + 8 * k));
      alarm_ld = (k == 0);
      step();
      $display("alarm1 k=%0d ns=%0d -> armed=%0b pulse=%0b late=%0b",
               k, 400 + 8 * k, alarm_armed, alarm_pulse, alarm_late);
      chk($sformatf("a1_armed_k%0d", k), 64'(alarm_armed), 64'(k < 13));
      chk($sformatf("a1_pulse_k%0d", k), 64'(alarm_pulse), 64'(k == 13));
    end
    chk("a1_late", 64'(alarm_late), 64'd0);

    // Target in the past: fires on first compare, marked late
    alarm_sec_in = 48'd3; alarm_ns_in = 30'd0; alarm_ld = 1'b1; step();
    alarm_ld = 1'b0;
    $display("alarm2 load -> armed=%0b pulse=%0b", alarm_armed, alarm_pulse);
    chk("a2_armed", 64'(alarm_armed), 64'd1);
    chk("a2_pulse0", 64'(alarm_pulse), 64'd0);
    step();
    $display("alarm2 fire -> armed=%0b pulse=%0b late=%0b", alarm_armed, alarm_pulse, alarm_late);
    chk("a2_pulse1", 64'(alarm_pulse), 64'd1);
    chk("a2_late", 64'(alarm_late), 64'd1);
    chk("a2_armed_fire", 64'(alarm_armed), 64'd0);
    step();
    chk("a2_pulse_end", 64'(alarm_pulse), 64'd0);
    chk("a2_late_sticky", 64'(alarm_late), 64'd1);

    // Fire again, then re-arm during FIRE with a future target
    alarm_ld = 1'b1; step(); alarm_ld = 1'b0; step();
    chk("a3_pulse", 64'(alarm_pulse), 64'd1);
    alarm_sec_in = 48'd1000; alarm_ld = 1'b1; step(); alarm_ld = 1'b0;
    $display("alarm3 rearm in FIRE -> armed=%0b late=%0b", alarm_armed, alarm_late);
    chk("a3_rearm", 64'(alarm_armed), 64'd1);
    chk("a3_late_clr", 64'(alarm_late), 64'd0);
    step();
    chk("a3_no_pulse", 64'(alarm_pulse), 64'd0);
    alarm_cancel = 1'b1; step(); alarm_cancel = 1'b0;
    chk("a3_cancel", 64'(alarm_armed), 64'd0);

    // Load and cancel together with a past target: no alarm
    alarm_ld = 1'b1; step();
    chk("a4_armed", 64'(alarm_armed), 64'd1);
    alarm_sec_in = 48'd3; alarm_cancel = 1'b1; step();
    alarm_ld = 1'b0; alarm_cancel = 1'b0;
    $display("alarm4 ld+cancel -> armed=%0b pulse=%0b", alarm_armed, alarm_pulse);
    chk("a4_cancel_armed", 64'(alarm_armed), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("a4_no_pulse%0d", k), 64'(alarm_pulse), 64'd0);
    end

    // Asynchronous reset while PPS high and alarm armed
    time_ld = 1'b1; time_reg_sec = 48'd20; step();
    time_ld = 1'b0; step();
    time_reg_sec = 48'd21; pps_width = 16'd10; step();
    alarm_sec_in = 48'd1000; alarm_ld = 1'b1; step(); alarm_ld = 1'b0;
    chk("r_pre_pps", 64'(pps_out), 64'd1);
    chk("r_pre_armed", 64'(alarm_armed), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset -> pps=%0b cnt=%0d armed=%0b", pps_out, pps_count, alarm_armed);
    chk("r_pps", 64'(pps_out), 64'd0);
    chk("r_cnt", 64'(pps_count), 64'd0);
    chk("r_armed", 64'(alarm_armed), 64'd0);
    chk("r_late", 64'(alarm_late), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("r_post_pulse%0d", k), 64'(alarm_pulse), 64'd0);
      chk($sformatf("r_post_armed%0d", k), 64'(alarm_armed), 64'd0);
      chk($sformatf("r_post_pps%0d", k), 64'(pps_out), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
